pipe_stage_reg: RTL and testbench

Parametrised, handshaked pipeline stage register that generalises the fixed per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) into one reusable block. Carries an arbitrary-width payload, usually a packed control word plus datapath fields, under a valid/ready handshake, with synchronous flush and an optional two-entry skid buffer. The skid buffer allows full throughput with a registered `in_ready`. Instantiated once per pipeline boundary; stall comes from downstream `out_ready`, squash from `flush`.

---
 rtl/pipe_stage_reg.sv | 112 +++++++++++
 tb/tb_pipe_stage_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg : handshaked pipeline boundary register, optional skid entry
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int               WIDTH      = 32,
  parameter int               SKID       = 1,
  parameter logic [WIDTH-1:0] RESET_DATA = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] w_skid_data;
  logic             w_in_fire;
  logic             w_out_fire;
  logic             w_load_main_in;
  logic             w_load_main_skid;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_in_fire) w_next_state = ST_ONE;
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_next_state = (SKID != 0) ? ST_FULL : ST_ONE;
          end else if (w_out_fire && !w_in_fire) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL:  if (w_out_fire) w_next_state = ST_ONE;
        default:  w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_comb begin
    out_valid = (r_state != ST_EMPTY);
    occupancy = r_state;
    out_data  = r_main_data;
  end

  // Incoming data goes straight to M when M is free or being drained this cycle
  assign w_load_main_in   = w_in_fire && ((r_state == ST_EMPTY) || w_out_fire);
  assign w_load_main_skid = (r_state == ST_FULL) && w_out_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main_data <= RESET_DATA;
    end else if (w_load_main_skid) begin
      r_main_data <= w_skid_data;
    end else if (w_load_main_in) begin
      r_main_data <= in_data;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [WIDTH-1:0] r_skid_data;
      logic             w_load_skid;

      assign w_load_skid = w_in_fire && (r_state == ST_ONE) && !w_out_fire;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_skid_data <= RESET_DATA;
        end else if (w_load_skid) begin
          r_skid_data <= in_data;
        end
      end

      assign w_skid_data = r_skid_data;
      // Pure function of registered state: no path from out_ready
      assign in_ready    = (r_state != ST_FULL);
    end else begin : g_no_skid
      assign w_skid_data = RESET_DATA;
      assign in_ready    = !out_valid || out_ready;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg : vectors, corner sequences and random scoreboard
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst_n;
  logic [1:0]  iv;
  logic [1:0]  ordy;
  logic [1:0]  fl;
  logic [1:0]  ov;
  logic [1:0]  ir;
  logic [31:0] idat [2];
  logic [31:0] odat [2];
  logic [1:0]  occ  [2];

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .RESET_DATA(32'hDEAD_BEEF)) u_skid (
    .clk(clk), .rst_n(rst_n), .flush(fl[0]),
    .in_valid(iv[0]), .in_ready(ir[0]), .in_data(idat[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odat[0]),
    .occupancy(occ[0])
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .RESET_DATA(32'h0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .flush(fl[1]),
    .in_valid(iv[1]), .in_ready(ir[1]), .in_data(idat[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odat[1]),
    .occupancy(occ[1])
  );

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        fl;
    logic        ev;
    logic [31:0] ed;
    logic [1:0]  eocc;
    logic        eir;
    logic        chkd;
  } vec_t;

  vec_t        vecs [16];
  logic [31:0] mq   [2][2];
  int          mcnt [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic ir_pre;
    logic exp_ir;
    logic fin;
    logic fout;

    // inputs, then outputs expected at the negedge of the same cycle
    vecs[0]  = '{1'b1, 32'hA,  1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 2'd0, 1'b1, 1'b1};
    vecs[1]  = '{1'b1, 32'hB,  1'b0, 1'b0, 1'b1, 32'hA,  2'd1, 1'b1, 1'b1};
    vecs[2]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2, 1'b0, 1'b1};
    vecs[3]  = '{1'b1, 32'hC,  1'b0, 1'b0, 1'b1, 32'hA,  2'd2, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 32'hA,  2'd2, 1'b0, 1'b1};
    vecs[5]  = '{1'b1, 32'hC,  1'b1, 1'b0, 1'b1, 32'hB,  2'd1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'hC,  2'd1, 1'b1, 1'b1};
    vecs[7]  = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'hC,  2'd0, 1'b1, 1'b1};
    vecs[8]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b0, 32'hC,  2'd0, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 32'h11, 2'd1, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 32'h55, 1'b0, 1'b1, 1'b1, 32'h11, 2'd2, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 32'h11, 2'd0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b1, 32'h66, 2'd1, 1'b1, 1'b1};
    vecs[13] = '{1'b1, 32'h77, 1'b1, 1'b0, 1'b0, 32'h66, 2'd0, 1'b1, 1'b1};
    vecs[14] = '{1'b1, 32'h88, 1'b1, 1'b1, 1'b1, 32'h77, 2'd1, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 32'h0,  1'b1, 1'b0, 1'b0, 32'h0,  2'd0, 1'b1, 1'b0};

    iv = '0; ordy = 2'b11; fl = '0; idat[0] = '0; idat[1] = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_ov_s",  {31'd0, ov[0]}, 32'd0);
    chk("rst_occ_s", {30'd0, occ[0]}, 32'd0);
    chk("rst_dat_s", odat[0], 32'hDEAD_BEEF);
    chk("rst_ir_s",  {31'd0, ir[0]}, 32'd1);
    chk("rst_ov_n",  {31'd0, ov[1]}, 32'd0);
    chk("rst_dat_n", odat[1], 32'd0);
    chk("rst_ir_n",  {31'd0, ir[1]}, 32'd1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    // Skid absorb and flush sequences on the SKID=1 instance
    for (int i = 0; i < 16; i++) begin
      #1;
      iv[0] = vecs[i].iv; idat[0] = vecs[i].id; ordy[0] = vecs[i].ordy; fl[0] = vecs[i].fl;
      @(negedge clk);
      chk($sformatf("vec%0d_ov", i),  {31'd0, ov[0]}, {31'd0, vecs[i].ev});
      chk($sformatf("vec%0d_occ", i), {30'd0, occ[0]}, {30'd0, vecs[i].eocc});
      chk($sformatf("vec%0d_ir", i),  {31'd0, ir[0]}, {31'd0, vecs[i].eir});
      if (vecs[i].chkd) chk($sformatf("vec%0d_dat", i), odat[0], vecs[i].ed);
      @(posedge clk);
    end
    fl = '0;

    // Streaming 1..16 with downstream always ready, both variants
    for (int c = 0; c <= 16; c++) begin
      #1;
      for (int d = 0; d < 2; d++) begin
        iv[d] = (c < 16); idat[d] = 32'(c + 1); ordy[d] = 1'b1;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("strm%0d_ir", d), {31'd0, ir[d]}, 32'd1);
        if (c >= 1) begin
          chk($sformatf("strm%0d_ov", d),  {31'd0, ov[d]}, 32'd1);
          chk($sformatf("strm%0d_dat", d), odat[d], 32'(c));
          chk($sformatf("strm%0d_occ", d), {30'd0, occ[d]}, 32'd1);
        end
      end
      @(posedge clk);
    end

    // Fill the skid instance, then reset it asynchronously mid-stream
    #1; iv = 2'b01; idat[0] = 32'h1; ordy = 2'b10;
    @(posedge clk);
    #1; idat[0] = 32'h2;
    @(posedge clk);
    #1; iv = '0;
    @(negedge clk);
    chk("full_occ", {30'd0, occ[0]}, 32'd2);
    chk("full_ir",  {31'd0, ir[0]}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_ov",  {31'd0, ov[0]}, 32'd0);
    chk("mid_rst_occ", {30'd0, occ[0]}, 32'd0);
    chk("mid_rst_dat", odat[0], 32'hDEAD_BEEF);
    chk("mid_rst_ir",  {31'd0, ir[0]}, 32'd1);
    chk("mid_rst_dat_n", odat[1], 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);

    // Random valid/ready/flush against a plain FIFO model
    mcnt[0] = 0; mcnt[1] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      #1;
      ir_pre = ir[0];
      for (int d = 0; d < 2; d++) begin
        iv[d]   = ($urandom_range(0, 9) < 7);
        ordy[d] = ($urandom_range(0, 9) < 6);
        fl[d]   = ($urandom_range(0, 49) == 0);
        idat[d] = $urandom;
      end
      @(negedge clk);
      chk("rnd_ir_stable", {31'd0, ir[0]}, {31'd0, ir_pre});
      for (int d = 0; d < 2; d++) begin
        exp_ir = (d == 0) ? (mcnt[d] < 2) : ((mcnt[d] == 0) || ordy[d]);
        chk($sformatf("rnd%0d_ov", d),  {31'd0, ov[d]}, {31'd0, mcnt[d] > 0});
        chk($sformatf("rnd%0d_occ", d), {30'd0, occ[d]}, 32'(mcnt[d]));
        chk($sformatf("rnd%0d_ir", d),  {31'd0, ir[d]}, {31'd0, exp_ir});
        if (mcnt[d] > 0) chk($sformatf("rnd%0d_dat", d), odat[d], mq[d][0]);
        fin  = iv[d] && exp_ir;
        fout = (mcnt[d] > 0) && ordy[d];
        if (fl[d]) begin
          mcnt[d] = 0;
        end else begin
          if (fout) begin
            mq[d][0] = mq[d][1];
            mcnt[d]--;
          end
          if (fin) begin
            mq[d][mcnt[d]] = idat[d];
            mcnt[d]++;
          end
        end
      end
      @(posedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
